// File: rtl/dual_port_ram_param.sv
// ============================================================================
// dual_port_ram_param
// Parametrised true dual-port synchronous RAM. Two independent read/write
// ports share one array on a single clock. Reads are read-before-write with a
// selectable latency of 1 or 2 clocks. Same-address write/write conflicts
// resolve to a fixed port. Out-of-range addresses are flagged instead of
// aliased. An optional post-reset sequence zeroes every word.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-high
//   enable_X            port X access request (X = A, B)
//   write_enable_X      port X write qualifier, only meaningful with enable_X
//   address_X           port X word address
//   data_in_X           port X write data
//   data_out_X          port X read data, held while valid_X is low
//   valid_X             one-cycle strobe, data_out_X carries a new result
//   addr_err_X          request was out of range (aligned with valid_X)
//   collision           same-address conflict, one clock after the request
//   busy                clear sequence in progress, requests are ignored
// ============================================================================
module dual_port_ram_param #(
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned DEPTH          = 256,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned COLLISION_MODE = 0,
   parameter int unsigned RESET_CLEAR    = 1
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              enable_A,
   input  logic              write_enable_A,
   input  logic [ADDR_W-1:0] address_A,
   input  logic [DATA_W-1:0] data_in_A,
   output logic [DATA_W-1:0] data_out_A,
   output logic              valid_A,
   output logic              addr_err_A,

   input  logic              enable_B,
   input  logic              write_enable_B,
   input  logic [ADDR_W-1:0] address_B,
   input  logic [DATA_W-1:0] data_in_B,
   output logic [DATA_W-1:0] data_out_B,
   output logic              valid_B,
   output logic              addr_err_B,

   output logic              collision,
   output logic              busy
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [ADDR_W-1:0] clr_cnt;
   logic              clr_last;
   logic              clr_we;
   logic              ready;

   logic [DATA_W-1:0] mem [DEPTH];

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= (RESET_CLEAR != 0) ? ST_CLEAR : ST_READY;
      end else begin
         state <= state_nxt;
      end
   end

   assign clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));

   // FSM: next-state logic; READY is only left through reset
   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (clr_last) state_nxt = ST_READY;
         ST_READY: state_nxt = ST_READY;
         default:  state_nxt = ST_READY;
      endcase
   end

   // FSM: output decode
   always_comb begin
      busy   = 1'b0;
      clr_we = 1'b0;
      ready  = 1'b0;
      case (state)
         ST_CLEAR: begin
            busy   = 1'b1;
            clr_we = ~reset;
         end
         ST_READY: ready = 1'b1;
         default:  ready = 1'b0;
      endcase
   end

   // Clear address counter; restarts from zero on every reset
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_cnt <= '0;
      end else if (clr_we) begin
         clr_cnt <= clr_last ? '0 : clr_cnt + ADDR_W'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------------
   logic              acc_a, acc_b;
   logic              oor_a, oor_b;
   logic              wr_a, wr_b;
   logic              conflict;
   logic              keep_a, keep_b;
   logic [IDX_W-1:0]  idx_a, idx_b;
   logic [DATA_W-1:0] rd_a, rd_b;

   assign acc_a = ready & enable_A & ~reset;
   assign acc_b = ready & enable_B & ~reset;

   // One extra bit so DEPTH == 2**ADDR_W compares correctly
   assign oor_a = ({1'b0, address_A} >= (ADDR_W + 1)'(DEPTH));
   assign oor_b = ({1'b0, address_B} >= (ADDR_W + 1)'(DEPTH));

   assign wr_a = acc_a & write_enable_A & ~oor_a;
   assign wr_b = acc_b & write_enable_B & ~oor_b;

   assign conflict = acc_a & acc_b & (address_A == address_B) & ~oor_a
                   & (write_enable_A | write_enable_B);

   // On a write/write conflict the losing port's write is dropped
   assign keep_a = wr_a & ~(conflict & wr_b & (COLLISION_MODE != 0));
   assign keep_b = wr_b & ~(conflict & wr_a & (COLLISION_MODE == 0));

   assign idx_a = address_A[IDX_W-1:0];
   assign idx_b = address_B[IDX_W-1:0];

   // Read-before-write: the array is sampled before this edge's updates land
   assign rd_a = (acc_a & ~oor_a) ? mem[idx_a] : '0;
   assign rd_b = (acc_b & ~oor_b) ? mem[idx_b] : '0;

   // ------------------------------------------------------------------------
   // Array writes: clear sequence or port writes (mutually exclusive by state)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_cnt[IDX_W-1:0]] <= '0;
      end
      if (keep_a) begin
         mem[idx_a] <= data_in_A;
      end
      if (keep_b) begin
         mem[idx_b] <= data_in_B;
      end
   end

   // ------------------------------------------------------------------------
   // Read pipeline; the final stage is the output register
   // ------------------------------------------------------------------------
   logic              p_v_a, p_e_a, p_v_b, p_e_b;
   logic [DATA_W-1:0] p_d_a, p_d_b;

   if (READ_LATENCY >= 2) begin : g_lat2
      logic              s1_v_a, s1_e_a, s1_v_b, s1_e_b;
      logic [DATA_W-1:0] s1_d_a, s1_d_b;

      // Extra stage between the array read and the output register
      always_ff @(posedge clk) begin
         if (reset) begin
            s1_v_a <= 1'b0;
            s1_e_a <= 1'b0;
            s1_d_a <= '0;
            s1_v_b <= 1'b0;
            s1_e_b <= 1'b0;
            s1_d_b <= '0;
         end else begin
            s1_v_a <= acc_a;
            s1_e_a <= acc_a & oor_a;
            s1_d_a <= rd_a;
            s1_v_b <= acc_b;
            s1_e_b <= acc_b & oor_b;
            s1_d_b <= rd_b;
         end
      end

      assign p_v_a = s1_v_a;
      assign p_e_a = s1_e_a;
      assign p_d_a = s1_d_a;
      assign p_v_b = s1_v_b;
      assign p_e_b = s1_e_b;
      assign p_d_b = s1_d_b;
   end else begin : g_lat1
      assign p_v_a = acc_a;
      assign p_e_a = acc_a & oor_a;
      assign p_d_a = rd_a;
      assign p_v_b = acc_b;
      assign p_e_b = acc_b & oor_b;
      assign p_d_b = rd_b;
   end

   // Output registers; data holds while no new result arrives
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_A    <= 1'b0;
         addr_err_A <= 1'b0;
         data_out_A <= '0;
         valid_B    <= 1'b0;
         addr_err_B <= 1'b0;
         data_out_B <= '0;
      end else begin
         valid_A    <= p_v_a;
         addr_err_A <= p_e_a;
         if (p_v_a) begin
            data_out_A <= p_d_a;
         end
         valid_B    <= p_v_b;
         addr_err_B <= p_e_b;
         if (p_v_b) begin
            data_out_B <= p_d_b;
         end
      end
   end

   // Collision flag is reported one clock after the request, independent of
   // read latency
   always_ff @(posedge clk) begin
      if (reset) begin
         collision <= 1'b0;
      end else begin
         collision <= conflict;
      end
   end

endmodule
